vga_frame_reader: RTL

- Read-side counterpart of the camera write path: generates 640x480@60 VGA timing and fetches pixels from the full frame buffer's VGA read port (raddr_vga/rdata_vga, 12-bit RGB444).
- Compensates for the buffer's read latency so RGB, syncs and data-enable stay aligned at the pins.
- Runs entirely in the sys_clk domain, with a pixel tick derived internally.

---
 rtl/vga_frame_reader_pkg.sv | 46 ++++
 rtl/vga_frame_reader_timing_gen.sv | 72 +++++++
 rtl/vga_frame_reader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vga_frame_reader_pkg.sv
// Shared constants, pipeline entry type and colour-bar lookup for the VGA read path.
// Default timing is 640x480@60 with a 25 MHz pixel rate derived from sys_clk.
package vga_frame_reader_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int ADDR_W = 19;
  localparam int PIX_W  = 12;
  localparam int CNT_W  = 10;

  // One entry per pixel tick; valid marks the slot that carries a real pixel.
  typedef struct packed {
    logic       valid;
    logic       active;
    logic       hs;
    logic       vs;
    logic       first;
    logic       pat;
    logic [2:0] bar;
  } pipe_t;

  function automatic logic [PIX_W-1:0] bar_colour(input logic [2:0] idx);
    logic [PIX_W-1:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_frame_reader_timing_gen.sv
// Pixel tick divider plus horizontal/vertical counters and the raw region flags
// decoded combinationally from the current counter values.
module vga_frame_reader_timing_gen
  import vga_frame_reader_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             sys_clk,
  input  logic             rst,
  output logic             tick_o,
  output logic [CNT_W-1:0] hcnt_o,
  output logic [CNT_W-1:0] vcnt_o,
  output logic             active_o,
  output logic             hs_raw_o,
  output logic             vs_raw_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             tick;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (hcnt_q == CNT_W'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign tick_o   = tick;
  assign hcnt_o   = hcnt_q;
  assign vcnt_o   = vcnt_q;
  assign active_o = (hcnt_q < CNT_W'(H_ACTIVE)) && (vcnt_q < CNT_W'(V_ACTIVE));
  assign hs_raw_o = (hcnt_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                    (hcnt_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw_o = (vcnt_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                    (vcnt_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_frame_reader.sv
// VGA read path: running frame-buffer address, read-latency pipeline for sync/DE,
// colour-bar test pattern and the pin registers, all in the sys_clk domain.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int RD_LAT   = 1,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              test_pattern,
  output logic [ADDR_W-1:0] raddr_vga,
  input  logic [PIX_W-1:0]  rdata_vga,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  logic             tick, active, hs_raw, vs_raw;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic             first_px, last_px, frame_end;

  vga_frame_reader_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .sys_clk (sys_clk),
    .rst     (rst),
    .tick_o  (tick),
    .hcnt_o  (hcnt),
    .vcnt_o  (vcnt),
    .active_o(active),
    .hs_raw_o(hs_raw),
    .vs_raw_o(vs_raw)
  );

  assign first_px  = (hcnt == '0) && (vcnt == '0);
  assign last_px   = (hcnt == CNT_W'(H_ACTIVE - 1)) && (vcnt == CNT_W'(V_ACTIVE - 1));
  assign frame_end = (hcnt == CNT_W'(H_TOTAL - 1)) && (vcnt == CNT_W'(V_TOTAL - 1));

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pat_q, pat_d;
  logic [2:0]        bar_idx;
  pipe_t             push, tail;
  pipe_t             pipe_q [RD_LAT];
  logic [PIX_W-1:0]  rgb_q, rgb_d;
  logic              hs_q, vs_q, de_q, fs_q;

  assign tail = pipe_q[RD_LAT-1];

  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (hcnt >= CNT_W'(i * BAR_W)) bar_idx = 3'(i);
    end

    // Holding at the last visible address keeps the counter within the buffer.
    addr_d = addr_q;
    if (tick) begin
      if (frame_end)              addr_d = '0;
      else if (active && !last_px) addr_d = addr_q + 1'b1;
    end

    // The first pixel of a frame already uses the freshly sampled mode.
    pat_d = (tick && first_px) ? test_pattern : pat_q;

    push        = '0;
    push.valid  = tick;
    push.active = active;
    push.hs     = hs_raw;
    push.vs     = vs_raw;
    push.first  = first_px;
    push.pat    = pat_d;
    push.bar    = bar_idx;

    if (!tail.active)  rgb_d = '0;
    else if (tail.pat) rgb_d = bar_colour(tail.bar);
    else               rgb_d = rdata_vga;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      pat_q  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      rgb_q  <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      pat_q     <= pat_d;
      pipe_q[0] <= push;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      fs_q <= tail.valid & tail.first;
      if (tail.valid) begin
        rgb_q <= rgb_d;
        de_q  <= tail.active;
        hs_q  <= ~tail.hs;
        vs_q  <= ~tail.vs;
      end
    end
  end

  assign raddr_vga   = addr_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign frame_start = fs_q;

endmodule
